// File: rtl/midi_pkg.sv
// Shared definitions for the MIDI serial port: FSM state encoding and
// frame/baud constants used by the transmitter and receiver.
package midi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam int MIDI_BAUD       = 31250;
    localparam int DATA_BITS       = 8;
    localparam int DEFAULT_DIVISOR = 32;

endpackage

// File: rtl/baud_divider.sv
// Bit-period timer: counts 0..DIVISOR-1 and flags the last cycle of each bit.
// restart forces the count back to 0 so a new frame starts on a clean boundary.
module baud_divider
    import midi_pkg::*;
#(
    parameter int DIVISOR = DEFAULT_DIVISOR
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int              CW   = $clog2(DIVISOR);
    localparam logic [CW-1:0]   LAST = CW'(DIVISOR - 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    assign tick = (count_reg == LAST);

    always_comb begin
        count_next = count_reg + CW'(1);
        if (restart || tick) begin
            count_next = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/midi_tx.sv
// MIDI 8N1 transmitter with a holding register in front of the shift register,
// so the next byte can be queued while the current frame is on the wire.
module midi_tx
    import midi_pkg::*;
#(
    parameter int DIVISOR   = DEFAULT_DIVISOR,
    parameter int STOP_BITS = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] d,
    input  logic       irq_en,
    output logic       txd,
    output logic       tdre,
    output logic       busy,
    output logic       irq
);

    tx_state_t  state_reg, state_next;
    logic [7:0] hold_reg, hold_next;
    logic [7:0] shift_reg, shift_next;
    logic       hold_full_reg, hold_full_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic       irq_reg;

    logic tick;
    logic accept;
    logic last_stop;
    logic transfer;
    logic shift_en;
    logic baud_restart;

    assign accept    = enable && !hold_full_reg;
    assign last_stop = (state_reg == ST_STOP) && tick && (bit_cnt_reg == 3'(STOP_BITS - 1));
    // A queued byte moves to the shifter either from idle or exactly at the
    // end of the final stop bit, which is what makes frames gapless.
    assign transfer  = hold_full_reg && ((state_reg == ST_IDLE) || last_stop);
    assign shift_en  = (state_reg == ST_DATA) && tick;
    assign baud_restart = (state_reg == ST_IDLE) || transfer;

    baud_divider #(
        .DIVISOR (DIVISOR)
    ) u_baud (
        .clock   (clock),
        .reset   (reset),
        .restart (baud_restart),
        .tick    (tick)
    );

    // LSB-first shifter; ones are shifted in so the line never sees stale data.
    for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_shift
        if (gi == DATA_BITS - 1) begin : g_top
            assign shift_next[gi] = transfer ? hold_reg[gi] :
                                    shift_en ? 1'b1 : shift_reg[gi];
        end else begin : g_low
            assign shift_next[gi] = transfer ? hold_reg[gi] :
                                    shift_en ? shift_reg[gi+1] : shift_reg[gi];
        end
    end

    always_comb begin
        hold_next      = hold_reg;
        hold_full_next = hold_full_reg;
        if (transfer) begin
            hold_full_next = 1'b0;
        end else if (accept) begin
            hold_next      = d;
            hold_full_next = 1'b1;
        end
    end

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (transfer) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_next   = ST_DATA;
                    bit_cnt_next = 3'd0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_cnt_reg == 3'(DATA_BITS - 1)) begin
                        state_next   = ST_STOP;
                        bit_cnt_next = 3'd0;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (last_stop) begin
                    state_next   = transfer ? ST_START : ST_IDLE;
                    bit_cnt_next = 3'd0;
                end else if (tick) begin
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                end
            end
            default: begin
                state_next   = ST_IDLE;
                bit_cnt_next = 3'd0;
            end
        endcase
    end

    always_comb begin
        txd = 1'b1;
        case (state_reg)
            ST_START: txd = 1'b0;
            ST_DATA:  txd = shift_reg[0];
            default:  txd = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            hold_reg      <= 8'h00;
            shift_reg     <= 8'h00;
            hold_full_reg <= 1'b0;
            bit_cnt_reg   <= 3'd0;
            irq_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            hold_reg      <= hold_next;
            shift_reg     <= shift_next;
            hold_full_reg <= hold_full_next;
            bit_cnt_reg   <= bit_cnt_next;
            irq_reg       <= irq_en && !hold_full_reg;
        end
    end

    assign tdre = !hold_full_reg;
    assign busy = (state_reg != ST_IDLE);
    assign irq  = irq_reg;

endmodule

// File: tb/tb_midi_tx.sv
// Directed bench for midi_tx: one-stop-bit and two-stop-bit instances at
// DIVISOR=4 share stimulus; per-cycle output traces are checked against a frame model.
module tb_midi_tx;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [7:0] d;
    logic       irq_en;
    logic       txd1, tdre1, busy1, irq1;
    logic       txd2, tdre2, busy2, irq2;

    int errors = 0;
    int checks = 0;
    int t = 0;

    // bit 0 = one-stop instance, bit 1 = two-stop instance
    logic [1:0] txd_tr  [0:1023];
    logic [1:0] busy_tr [0:1023];
    logic [1:0] tdre_tr [0:1023];
    logic [1:0] irq_tr  [0:1023];

    midi_tx #(.DIVISOR(4), .STOP_BITS(1)) dut1 (
        .clock(clock), .reset(reset), .enable(enable), .d(d), .irq_en(irq_en),
        .txd(txd1), .tdre(tdre1), .busy(busy1), .irq(irq1)
    );

    midi_tx #(.DIVISOR(4), .STOP_BITS(2)) dut2 (
        .clock(clock), .reset(reset), .enable(enable), .d(d), .irq_en(irq_en),
        .txd(txd2), .tdre(tdre2), .busy(busy2), .irq(irq2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Record outputs at the falling edge, then present inputs for the next rising edge.
    task automatic cyc(input logic en, input logic [7:0] dv);
        @(negedge clock);
        if (t < 1024) begin
            txd_tr[t]  = {txd2, txd1};
            busy_tr[t] = {busy2, busy1};
            tdre_tr[t] = {tdre2, tdre1};
            irq_tr[t]  = {irq2, irq1};
        end
        t++;
        enable = en;
        d      = dv;
    endtask

    function automatic logic [127:0] pack_tr(input int kind, input int sel, input int start, input int n);
        logic [127:0] r;
        int idx;
        r = '0;
        for (int i = 0; i < n && i < 128; i++) begin
            idx = start + i;
            if (idx >= 0 && idx < 1024) begin
                case (kind)
                    0:       r[i] = txd_tr[idx][sel];
                    1:       r[i] = busy_tr[idx][sel];
                    2:       r[i] = irq_tr[idx][sel];
                    default: r[i] = tdre_tr[idx][sel];
                endcase
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mask_n(input int n);
        logic [127:0] m;
        m = '0;
        for (int i = 0; i < n && i < 128; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Expected line level for 'frames' consecutive frames (b1 then b2), DIVISOR=4.
    function automatic logic [127:0] model_txd(input logic [7:0] b1, input logic [7:0] b2,
                                               input int frames, input int stops);
        logic [127:0] r;
        logic [7:0]   b;
        int fl, f, p;
        fl = (9 + stops) * 4;
        r  = '0;
        for (int c = 0; c < 128; c++) begin
            f = c / fl;
            p = c % fl;
            b = (f == 0) ? b1 : b2;
            if (f >= frames)  r[c] = 1'b1;
            else if (p < 4)   r[c] = 1'b0;
            else if (p < 36)  r[c] = b[(p - 4) / 4];
            else              r[c] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [127:0] model_busy(input int frames, input int stops);
        return mask_n(frames * (9 + stops) * 4);
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (txd_tr[t-1] !== 2'b11)  begin errors++; $display("FAIL reset_txd got=%b exp=11", txd_tr[t-1]); end
        checks++; if (tdre_tr[t-1] !== 2'b11) begin errors++; $display("FAIL reset_tdre got=%b exp=11", tdre_tr[t-1]); end
        checks++; if (busy_tr[t-1] !== 2'b00) begin errors++; $display("FAIL reset_busy got=%b exp=00", busy_tr[t-1]); end
        checks++; if (irq_tr[t-1] !== 2'b00)  begin errors++; $display("FAIL reset_irq got=%b exp=00", irq_tr[t-1]); end
        $display("reset: txd=%b tdre=%b busy=%b irq=%b", txd_tr[t-1], tdre_tr[t-1], busy_tr[t-1], irq_tr[t-1]);
    endtask

    task automatic test_single();
        int t0;
        logic [127:0] obs, exp;
        do_reset();
        t0 = t;
        cyc(1'b1, 8'h90);
        repeat (44) cyc(1'b0, 8'h00);
        checks++; if (tdre_tr[t0+1][0] !== 1'b0) begin errors++; $display("FAIL single_tdre_low got=%b exp=0", tdre_tr[t0+1][0]); end
        checks++; if (tdre_tr[t0+2][0] !== 1'b1) begin errors++; $display("FAIL single_tdre_back got=%b exp=1", tdre_tr[t0+2][0]); end
        obs = pack_tr(0, 0, t0 + 2, 41);
        exp = model_txd(8'h90, 8'h00, 1, 1) & mask_n(41);
        checks++; if (obs !== exp) begin errors++; $display("FAIL single_txd got=%h exp=%h", obs, exp); end
        obs = pack_tr(1, 0, t0 + 2, 41);
        exp = model_busy(1, 1) & mask_n(41);
        checks++; if (obs !== exp) begin errors++; $display("FAIL single_busy got=%h exp=%h", obs, exp); end
        $display("single 0x90: txd trace=%h", pack_tr(0, 0, t0 + 2, 41));
    endtask

    task automatic test_back_to_back();
        int t0;
        logic [127:0] obs, exp;
        do_reset();
        t0 = t;
        cyc(1'b1, 8'h3C);
        cyc(1'b1, 8'h7F);
        cyc(1'b1, 8'h64);
        repeat (84) cyc(1'b0, 8'h00);
        checks++; if (tdre_tr[t0+1][0] !== 1'b0) begin errors++; $display("FAIL b2b_tdre_n1 got=%b exp=0", tdre_tr[t0+1][0]); end
        checks++; if (tdre_tr[t0+2][0] !== 1'b1) begin errors++; $display("FAIL b2b_tdre_n2 got=%b exp=1", tdre_tr[t0+2][0]); end
        checks++; if (tdre_tr[t0+3][0] !== 1'b0) begin errors++; $display("FAIL b2b_tdre_queued got=%b exp=0", tdre_tr[t0+3][0]); end
        checks++; if (tdre_tr[t0+41][0] !== 1'b0) begin errors++; $display("FAIL b2b_tdre_last_stop got=%b exp=0", tdre_tr[t0+41][0]); end
        checks++; if (tdre_tr[t0+42][0] !== 1'b1) begin errors++; $display("FAIL b2b_tdre_boundary got=%b exp=1", tdre_tr[t0+42][0]); end
        obs = pack_tr(0, 0, t0 + 2, 81);
        exp = model_txd(8'h3C, 8'h64, 2, 1) & mask_n(81);
        checks++; if (obs !== exp) begin errors++; $display("FAIL b2b_txd got=%h exp=%h", obs, exp); end
        obs = pack_tr(1, 0, t0 + 2, 81);
        exp = model_busy(2, 1) & mask_n(81);
        checks++; if (obs !== exp) begin errors++; $display("FAIL b2b_busy got=%h exp=%h", obs, exp); end
        $display("back_to_back 0x3C,0x64: txd trace=%h", pack_tr(0, 0, t0 + 2, 81));
    endtask

    task automatic test_two_stop();
        int t0;
        logic [127:0] obs, exp;
        do_reset();
        t0 = t;
        cyc(1'b1, 8'hFF);
        repeat (46) cyc(1'b0, 8'h00);
        obs = pack_tr(0, 1, t0 + 2, 45);
        exp = model_txd(8'hFF, 8'h00, 1, 2) & mask_n(45);
        checks++; if (obs !== exp) begin errors++; $display("FAIL two_stop_txd got=%h exp=%h", obs, exp); end
        obs = pack_tr(1, 1, t0 + 2, 45);
        exp = model_busy(1, 2) & mask_n(45);
        checks++; if (obs !== exp) begin errors++; $display("FAIL two_stop_busy got=%h exp=%h", obs, exp); end
        $display("two_stop 0xFF: busy trace=%h", pack_tr(1, 1, t0 + 2, 45));
    endtask

    task automatic test_irq();
        int t0, t1;
        logic [127:0] obs;
        do_reset();
        irq_en = 1'b1;
        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);
        t0 = t;
        cyc(1'b1, 8'h00);
        repeat (5) cyc(1'b0, 8'h00);
        obs = pack_tr(2, 0, t0, 5);
        checks++; if (obs !== 128'h1B) begin errors++; $display("FAIL irq_pulse_1stop got=%h exp=1b", obs); end
        obs = pack_tr(2, 1, t0, 5);
        checks++; if (obs !== 128'h1B) begin errors++; $display("FAIL irq_pulse_2stop got=%h exp=1b", obs); end
        irq_en = 1'b0;
        t1 = t;
        cyc(1'b1, 8'h11);
        repeat (4) cyc(1'b0, 8'h00);
        obs = pack_tr(2, 0, t1, 5);
        checks++; if (obs !== 128'h0) begin errors++; $display("FAIL irq_disabled got=%h exp=0", obs); end
        $display("irq: enabled trace=%h disabled trace=%h", pack_tr(2, 0, t0, 5), obs);
    endtask

    task automatic test_reset_mid();
        int t0, r, t2;
        logic [127:0] obs, exp;
        do_reset();
        t0 = t;
        cyc(1'b1, 8'hF0);
        cyc(1'b0, 8'h00);
        cyc(1'b1, 8'h77);
        while (t < t0 + 20) cyc(1'b0, 8'h00);
        // last recorded sample sits inside data bit 3 of the 0xF0 frame
        checks++; if (busy_tr[t-1][0] !== 1'b1) begin errors++; $display("FAIL mid_busy_before got=%b exp=1", busy_tr[t-1][0]); end
        checks++; if (tdre_tr[t-1][0] !== 1'b0) begin errors++; $display("FAIL mid_queued_before got=%b exp=0", tdre_tr[t-1][0]); end
        reset = 1'b1;
        r = t;
        cyc(1'b0, 8'h00);
        reset = 1'b0;
        checks++; if (txd_tr[r][0] !== 1'b1)  begin errors++; $display("FAIL mid_txd got=%b exp=1", txd_tr[r][0]); end
        checks++; if (tdre_tr[r][0] !== 1'b1) begin errors++; $display("FAIL mid_tdre got=%b exp=1", tdre_tr[r][0]); end
        checks++; if (busy_tr[r][0] !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", busy_tr[r][0]); end
        repeat (4) cyc(1'b0, 8'h00);
        obs = pack_tr(1, 0, r, 5);
        checks++; if (obs !== 128'h0) begin errors++; $display("FAIL mid_queue_discarded got=%h exp=0", obs); end
        t2 = t;
        cyc(1'b1, 8'hA5);
        repeat (44) cyc(1'b0, 8'h00);
        obs = pack_tr(0, 0, t2 + 2, 41);
        exp = model_txd(8'hA5, 8'h00, 1, 1) & mask_n(41);
        checks++; if (obs !== exp) begin errors++; $display("FAIL mid_after_txd got=%h exp=%h", obs, exp); end
        $display("reset_mid: post-reset 0xA5 txd trace=%h", obs);
    endtask

    task automatic test_enable_held();
        int t0;
        logic [127:0] obs, exp;
        do_reset();
        t0 = t;
        cyc(1'b1, 8'h12);
        repeat (9) cyc(1'b1, 8'h34);
        repeat (80) cyc(1'b0, 8'h00);
        checks++; if (tdre_tr[t0+2][0] !== 1'b1)  begin errors++; $display("FAIL held_tdre_rise got=%b exp=1", tdre_tr[t0+2][0]); end
        checks++; if (tdre_tr[t0+3][0] !== 1'b0)  begin errors++; $display("FAIL held_second_load got=%b exp=0", tdre_tr[t0+3][0]); end
        checks++; if (tdre_tr[t0+10][0] !== 1'b0) begin errors++; $display("FAIL held_tdre_stays got=%b exp=0", tdre_tr[t0+10][0]); end
        obs = pack_tr(0, 0, t0 + 2, 81);
        exp = model_txd(8'h12, 8'h34, 2, 1) & mask_n(81);
        checks++; if (obs !== exp) begin errors++; $display("FAIL held_txd got=%h exp=%h", obs, exp); end
        obs = pack_tr(1, 0, t0 + 2, 81);
        exp = model_busy(2, 1) & mask_n(81);
        checks++; if (obs !== exp) begin errors++; $display("FAIL held_busy got=%h exp=%h", obs, exp); end
        $display("enable_held 0x12,0x34: txd trace=%h", pack_tr(0, 0, t0 + 2, 81));
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        d      = 8'h00;
        irq_en = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_two_stop();
        test_irq();
        test_reset_mid();
        test_enable_held();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
